// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU and one peripheral, CPU priority with starvation guard.
// Define DMEM_ARB_PERF_EN to add saturating conflict/forced-grant performance counters.
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wEn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dataIn,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_dataOut,
    input  logic              per_req,
    input  logic              per_wEn,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_dataIn,
    output logic              per_gnt,
    output logic              per_rvalid,
    output logic [DATA_W-1:0] per_dataOut,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_conflicts,
    output logic [15:0]       perf_forced
`endif
);
    localparam logic [1:0] NONE = 2'd0;
    localparam logic [1:0] CPU  = 2'd1;
    localparam logic [1:0] PER  = 2'd2;

    logic [3:0]        wait_cnt;
    logic [1:0]        rd_owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] cpu_hold, per_hold;
    logic              conflict, forced;

    assign conflict = cpu_req & per_req;
    assign forced   = conflict & (wait_cnt >= 4'(MAX_WAIT));

    always_comb begin
        cpu_gnt     = !reset & cpu_req & !forced;
        per_gnt     = !reset & per_req & (!cpu_req | forced);
        ram_wEn     = cpu_gnt ? cpu_wEn : per_gnt ? per_wEn : 1'b0;
        ram_addr    = reset ? '0 : cpu_gnt ? cpu_addr : per_gnt ? per_addr : addr_q;
        ram_dataIn  = cpu_gnt ? cpu_dataIn : per_gnt ? per_dataIn : '0;
        cpu_rvalid  = !reset & (rd_owner == CPU);
        per_rvalid  = !reset & (rd_owner == PER);
        cpu_dataOut = reset ? '0 : cpu_rvalid ? ram_dataOut : cpu_hold;
        per_dataOut = reset ? '0 : per_rvalid ? ram_dataOut : per_hold;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
            rd_owner <= NONE;
            addr_q   <= '0;
            cpu_hold <= '0;
            per_hold <= '0;
        end else begin
            wait_cnt <= (per_gnt | !per_req) ? 4'd0 : (wait_cnt == 4'd15) ? wait_cnt : wait_cnt + 4'd1;
            rd_owner <= (cpu_gnt & !cpu_wEn) ? CPU : (per_gnt & !per_wEn) ? PER : NONE;
            addr_q   <= ram_addr;
            cpu_hold <= cpu_dataOut;
            per_hold <= per_dataOut;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_conflicts <= '0;
            perf_forced    <= '0;
        end else begin
            if (conflict && perf_conflicts != 16'hFFFF) perf_conflicts <= perf_conflicts + 16'd1;
            if (forced && perf_forced != 16'hFFFF) perf_forced <= perf_forced + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a behavioural synchronous-read RAM.
module tb_dmem_arbiter;
    logic        clock = 0, reset = 1;
    logic        cpu_req = 0, cpu_wEn = 0, per_req = 0, per_wEn = 0;
    logic [11:0] cpu_addr = 0, per_addr = 0;
    logic [31:0] cpu_dataIn = 0, per_dataIn = 0;
    logic        cpu_gnt, cpu_rvalid, per_gnt, per_rvalid, ram_wEn;
    logic [31:0] cpu_dataOut, per_dataOut, ram_dataIn, ram_dataOut;
    logic [11:0] ram_addr;
    logic [31:0] mem [0:4095];
    int          n_cmp = 0, n_fail = 0;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_conflicts, perf_forced;
`endif

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_wEn(cpu_wEn), .cpu_addr(cpu_addr), .cpu_dataIn(cpu_dataIn),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_dataOut(cpu_dataOut),
        .per_req(per_req), .per_wEn(per_wEn), .per_addr(per_addr), .per_dataIn(per_dataIn),
        .per_gnt(per_gnt), .per_rvalid(per_rvalid), .per_dataOut(per_dataOut),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
`ifdef DMEM_ARB_PERF_EN
        , .perf_conflicts(perf_conflicts), .perf_forced(perf_forced)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= mem[ram_addr];
    end

    task automatic test_reset();
        cpu_req = 1; per_req = 1; cpu_addr = 12'h123; per_addr = 12'h456; cpu_dataIn = 32'h1; per_dataIn = 32'h2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); #1;
            n_cmp++; if ({cpu_gnt, per_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_gnt got %b want 00", {cpu_gnt, per_gnt}); end
            n_cmp++; if ({cpu_rvalid, per_rvalid, ram_wEn} !== 3'b000) begin n_fail++; $display("FAIL rst_valid_wen got %b want 000", {cpu_rvalid, per_rvalid, ram_wEn}); end
            n_cmp++; if (ram_addr !== 12'h0 || ram_dataIn !== 32'h0) begin n_fail++; $display("FAIL rst_ram got %h/%h want 0/0", ram_addr, ram_dataIn); end
            n_cmp++; if (cpu_dataOut !== 32'h0 || per_dataOut !== 32'h0) begin n_fail++; $display("FAIL rst_dout got %h/%h want 0/0", cpu_dataOut, per_dataOut); end
        end
        @(negedge clock); reset = 0; cpu_req = 0; per_req = 0;
    endtask

    task automatic test_starvation();
        logic prev_per = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i == 0) begin
                cpu_req = 1; cpu_wEn = 0; cpu_addr = 12'h100;
                per_req = 1; per_wEn = 0; per_addr = 12'h200;
            end
            #1;
            n_cmp++; if (per_gnt !== (i % 5 == 4) || cpu_gnt !== (i % 5 != 4)) begin n_fail++; $display("FAIL starve_gnt cyc %0d got cpu=%b per=%b want per=%b", i, cpu_gnt, per_gnt, (i % 5 == 4)); end
            n_cmp++; if (ram_addr !== ((i % 5 == 4) ? 12'h200 : 12'h100)) begin n_fail++; $display("FAIL starve_addr cyc %0d got %h", i, ram_addr); end
            n_cmp++; if (cpu_rvalid !== (i > 0 && !prev_per) || per_rvalid !== (i > 0 && prev_per)) begin n_fail++; $display("FAIL starve_rvalid cyc %0d got cpu=%b per=%b", i, cpu_rvalid, per_rvalid); end
            prev_per = (i % 5 == 4);
        end
        @(negedge clock); cpu_req = 0; per_req = 0;
        @(negedge clock);
    endtask

    task automatic test_cpu_roundtrip();
        @(negedge clock); cpu_req = 1; cpu_wEn = 1; cpu_addr = 12'h010; cpu_dataIn = 32'hDEADBEEF; #1;
        n_cmp++; if (cpu_gnt !== 1 || ram_wEn !== 1 || ram_addr !== 12'h010 || ram_dataIn !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rt_write got gnt=%b wen=%b addr=%h data=%h want 1/1/010/deadbeef", cpu_gnt, ram_wEn, ram_addr, ram_dataIn); end
        @(negedge clock); cpu_wEn = 0; cpu_dataIn = 32'h0; #1;
        n_cmp++; if (cpu_gnt !== 1 || ram_wEn !== 0 || cpu_rvalid !== 0) begin n_fail++; $display("FAIL rt_read_gnt got gnt=%b wen=%b rv=%b want 1/0/0", cpu_gnt, ram_wEn, cpu_rvalid); end
        @(negedge clock); cpu_req = 0; #1;
        n_cmp++; if (cpu_rvalid !== 1 || cpu_dataOut !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rt_rdata got rv=%b data=%h want 1/deadbeef", cpu_rvalid, cpu_dataOut); end
        n_cmp++; if (per_rvalid !== 0) begin n_fail++; $display("FAIL rt_per_rvalid got %b want 0", per_rvalid); end
        n_cmp++; if (ram_wEn !== 0 || ram_addr !== 12'h010 || ram_dataIn !== 32'h0) begin n_fail++; $display("FAIL rt_idle_ram got wen=%b addr=%h data=%h want 0/010/0", ram_wEn, ram_addr, ram_dataIn); end
        @(negedge clock); #1;
        n_cmp++; if (cpu_rvalid !== 0 || cpu_dataOut !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rt_hold got rv=%b data=%h want 0/deadbeef", cpu_rvalid, cpu_dataOut); end
    endtask

    task automatic test_back_to_back();
        @(negedge clock); per_req = 1; per_wEn = 1; per_addr = 12'hFFF; per_dataIn = 32'h12345678; #1;
        n_cmp++; if (per_gnt !== 1 || cpu_gnt !== 0 || ram_wEn !== 1 || ram_addr !== 12'hFFF) begin n_fail++; $display("FAIL b2b_per_write got pg=%b cg=%b wen=%b addr=%h", per_gnt, cpu_gnt, ram_wEn, ram_addr); end
        @(negedge clock); per_req = 0; cpu_req = 1; cpu_wEn = 1; cpu_addr = 12'h000; cpu_dataIn = 32'hA5A5A5A5; #1;
        n_cmp++; if (cpu_gnt !== 1 || ram_addr !== 12'h000 || ram_dataIn !== 32'hA5A5A5A5 || per_rvalid !== 0) begin n_fail++; $display("FAIL b2b_cpu_write got cg=%b addr=%h data=%h prv=%b", cpu_gnt, ram_addr, ram_dataIn, per_rvalid); end
        @(negedge clock); cpu_req = 0; per_req = 1; per_wEn = 0; per_addr = 12'hFFF; per_dataIn = 0; #1;
        n_cmp++; if (per_gnt !== 1 || ram_wEn !== 0) begin n_fail++; $display("FAIL b2b_per_read_gnt got pg=%b wen=%b", per_gnt, ram_wEn); end
        @(negedge clock); per_req = 0; cpu_req = 1; cpu_wEn = 0; cpu_addr = 12'h000; #1;
        n_cmp++; if (cpu_gnt !== 1 || per_rvalid !== 1 || cpu_rvalid !== 0 || per_dataOut !== 32'h12345678) begin n_fail++; $display("FAIL b2b_per_ret got cg=%b prv=%b crv=%b pdata=%h want 1/1/0/12345678", cpu_gnt, per_rvalid, cpu_rvalid, per_dataOut); end
        @(negedge clock); cpu_addr = 12'hFFF; #1;
        n_cmp++; if (cpu_rvalid !== 1 || per_rvalid !== 0 || cpu_dataOut !== 32'hA5A5A5A5 || per_dataOut !== 32'h12345678) begin n_fail++; $display("FAIL b2b_cpu_ret got crv=%b prv=%b cdata=%h pdata=%h", cpu_rvalid, per_rvalid, cpu_dataOut, per_dataOut); end
        @(negedge clock); cpu_addr = 12'h010; #1;
        n_cmp++; if (cpu_rvalid !== 1 || cpu_dataOut !== 32'h12345678) begin n_fail++; $display("FAIL b2b_cpu_rd2 got rv=%b data=%h want 1/12345678", cpu_rvalid, cpu_dataOut); end
        @(negedge clock); cpu_req = 0; #1;
        n_cmp++; if (cpu_rvalid !== 1 || cpu_dataOut !== 32'hDEADBEEF || per_rvalid !== 0) begin n_fail++; $display("FAIL b2b_cpu_rd3 got rv=%b data=%h prv=%b want 1/deadbeef/0", cpu_rvalid, cpu_dataOut, per_rvalid); end
        @(negedge clock); #1;
        n_cmp++; if (cpu_rvalid !== 0 || per_rvalid !== 0) begin n_fail++; $display("FAIL b2b_quiet got crv=%b prv=%b want 0/0", cpu_rvalid, per_rvalid); end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clock); cpu_req = 1; cpu_wEn = 0; cpu_addr = 12'h010; #1;
        n_cmp++; if (cpu_gnt !== 1) begin n_fail++; $display("FAIL mid_gnt got %b want 1", cpu_gnt); end
        @(negedge clock); cpu_req = 0; reset = 1; #1;
        n_cmp++; if (cpu_rvalid !== 0 || cpu_dataOut !== 32'h0) begin n_fail++; $display("FAIL mid_rst got rv=%b data=%h want 0/0", cpu_rvalid, cpu_dataOut); end
        @(negedge clock); reset = 0; #1;
        n_cmp++; if (cpu_rvalid !== 0 || per_rvalid !== 0 || cpu_dataOut !== 32'h0) begin n_fail++; $display("FAIL mid_after got crv=%b prv=%b data=%h want 0/0/0", cpu_rvalid, per_rvalid, cpu_dataOut); end
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf();
        @(negedge clock); reset = 1;
        @(negedge clock); reset = 0; cpu_req = 1; per_req = 1; cpu_wEn = 0; per_wEn = 0;
        repeat (9) @(negedge clock);
        @(negedge clock); cpu_req = 0; per_req = 0; #1;
        n_cmp++; if (perf_conflicts !== 16'd10 || perf_forced !== 16'd2) begin n_fail++; $display("FAIL perf got conf=%0d forced=%0d want 10/2", perf_conflicts, perf_forced); end
    endtask
`endif

    initial begin
        test_reset();
        test_starvation();
        test_cpu_roundtrip();
        test_back_to_back();
        test_reset_mid_read();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
